// File: rtl/alu_pkg.sv
// Shared datapath definitions for the ALU/multiplier slice: widths, step
// count and the multiplier state encoding.
package alu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MULT_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/full_adder.sv
// Shared ripple-carry adder owned by the datapath parent; the ALU and the
// shift-add multiplier time-share this single instance.
module full_adder #(
  parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] y,
  output logic             c_out
);

  assign {c_out, y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier. One partial-product iteration per
// clock, using the parent's shared adder through the ADD_* port group.
module shift_add_multiplier #(
  parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   MULTIPLICAND,
  input  logic [WIDTH-1:0]   MULTIPLIER,
  output logic               READY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0]   ADD_A,
  output logic [WIDTH-1:0]   ADD_B,
  output logic               ADD_C_IN,
  input  logic [WIDTH-1:0]   ADD_Y,
  input  logic               ADD_C_OUT
);

  localparam logic [2:0] LAST_STEP = 3'(alu_pkg::MULT_STEPS - 1);

  alu_pkg::mult_state_t state;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     p_hi;
  logic [WIDTH-1:0]     p_lo;
  logic [2:0]           cnt;

  logic [WIDTH-1:0]     step_sum;
  logic                 step_carry;

  // The adder is fed only from registers, so there is no input-to-output path.
  assign ADD_A    = p_hi;
  assign ADD_B    = p_lo[0] ? m_reg : '0;
  assign ADD_C_IN = 1'b0;

  assign READY   = (state == alu_pkg::IDLE);
  assign DONE    = (state == alu_pkg::DONE);
  assign PRODUCT = {p_hi, p_lo};

  // When the multiplier bit is 0 the adder result is ignored entirely.
  always_comb begin
    step_sum   = p_hi;
    step_carry = 1'b0;
    if (p_lo[0]) begin
      step_sum   = ADD_Y;
      step_carry = ADD_C_OUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= alu_pkg::IDLE;
      m_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        alu_pkg::IDLE: begin
          if (START) begin
            m_reg <= MULTIPLICAND;
            p_lo  <= MULTIPLIER;
            p_hi  <= '0;
            cnt   <= '0;
            state <= alu_pkg::RUN;
          end
        end
        alu_pkg::RUN: begin
          // 17-bit {carry, sum, p_lo} shifted right by one.
          {p_hi, p_lo} <= {step_carry, step_sum, p_lo[WIDTH-1:1]};
          cnt          <= cnt + 3'd1;
          if (cnt == LAST_STEP) begin
            state <= alu_pkg::DONE;
          end
        end
        alu_pkg::DONE: begin
          state <= alu_pkg::IDLE;
        end
        default: begin
          state <= alu_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier wired to a real full_adder, with
// hand-computed expected products and cycle-exact handshake checks.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        ready;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_c_in;
  logic [7:0]  add_y;
  logic        add_c_out;

  int vectors;
  int miscompares;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .START        (start),
    .MULTIPLICAND (multiplicand),
    .MULTIPLIER   (multiplier),
    .READY        (ready),
    .DONE         (done),
    .PRODUCT      (product),
    .ADD_A        (add_a),
    .ADD_B        (add_b),
    .ADD_C_IN     (add_c_in),
    .ADD_Y        (add_y),
    .ADD_C_OUT    (add_c_out)
  );

  full_adder #(.WIDTH(8)) adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_c_in),
    .y     (add_y),
    .c_out (add_c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_product got %h want 0000", product); end
    vectors++; if (add_a !== 8'h00 || add_b !== 8'h00 || add_c_in !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_adder got a=%h b=%h cin=%b want 00 00 0", add_a, add_b, add_c_in); end
    // Reset and start together: reset wins and the request is dropped.
    rst = 1'b1; start = 1'b1; multiplicand = 8'h22; multiplier = 8'h33;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++; if (ready !== 1'b1 || product !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_start_drop got ready=%b prod=%h want 1 0000", ready, product); end
  endtask

  task automatic test_multiply(input string name, input logic [7:0] m, input logic [7:0] q,
                               input logic [15:0] expected, input bit check_zero_b);
    int done_count;
    done_count = 0;
    start = 1'b1; multiplicand = m; multiplier = q;
    @(negedge clk);
    start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_ready_fall got %b want 0", name, ready); end
    for (int i = 1; i <= 8; i++) begin
      if (check_zero_b) begin
        vectors++; if (add_b !== 8'h00) begin miscompares++; $display("[TB] FAIL %s_add_b_zero cycle %0d got %h want 00", name, i, add_b); end
      end
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_done_at_9 got %b want 1", name, done); end
    vectors++; if (product !== expected) begin miscompares++; $display("[TB] FAIL %s_product got %h want %h", name, product, expected); end
    @(negedge clk);
    vectors++; if (ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_back_idle got ready=%b done=%b want 1 0", name, ready, done); end
    vectors++; if (done_count != 1) begin miscompares++; $display("[TB] FAIL %s_done_pulses got %0d want 1", name, done_count); end
    vectors++; if (product !== expected) begin miscompares++; $display("[TB] FAIL %s_product_held got %h want %h", name, product, expected); end
  endtask

  task automatic test_busy();
    int done_count;
    done_count = 0;
    start = 1'b1; multiplicand = 8'h03; multiplier = 8'h05;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      start = (i == 3);
      multiplicand = (i == 3) ? 8'hFF : 8'h00;
      multiplier   = (i == 3) ? 8'hFF : 8'h00;
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
    // Re-request during the DONE cycle must also be ignored.
    start = 1'b1; multiplicand = 8'hFF; multiplier = 8'hFF;
    vectors++; if (product !== 16'h000F) begin miscompares++; $display("[TB] FAIL busy_product got %h want 000f", product); end
    @(negedge clk);
    start = 1'b0;
    vectors++; if (ready !== 1'b1 || product !== 16'h000F) begin miscompares++; $display("[TB] FAIL busy_idle got ready=%b prod=%h want 1 000f", ready, product); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
    vectors++; if (done_count != 1) begin miscompares++; $display("[TB] FAIL busy_done_pulses got %0d want 1", done_count); end
  endtask

  task automatic test_reset_mid();
    int done_count;
    done_count = 0;
    start = 1'b1; multiplicand = 8'hC3; multiplier = 8'h7E;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_state got ready=%b done=%b want 1 0", ready, done); end
    vectors++; if (product !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_mid_product got %h want 0000", product); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_count++;
    end
    vectors++; if (done_count != 0) begin miscompares++; $display("[TB] FAIL rst_mid_no_done got %0d want 0", done_count); end
    test_multiply("after_rst", 8'h10, 8'h10, 16'h0100, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vm [3];
    logic [7:0]  vq [3];
    logic [15:0] vp [3];
    int          done_count;
    vm[0] = 8'h12; vq[0] = 8'h34; vp[0] = 16'h03A8;
    vm[1] = 8'h80; vq[1] = 8'h02; vp[1] = 16'h0100;
    vm[2] = 8'hA5; vq[2] = 8'h3C; vp[2] = 16'h26AC;
    start = 1'b1; multiplicand = vm[0]; multiplier = vq[0];
    for (int v = 0; v < 3; v++) begin
      done_count = 0;
      @(negedge clk);
      multiplicand = (v < 2) ? vm[v+1] : 8'hFF;
      multiplier   = (v < 2) ? vq[v+1] : 8'hFF;
      if (v == 2) start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
        if (i == 9) begin
          vectors++; if (done !== 1'b1 || product !== vp[v]) begin miscompares++; $display("[TB] FAIL b2b_%0d got done=%b prod=%h want 1 %h", v, done, product, vp[v]); end
        end
        if (done === 1'b1) done_count++;
        @(negedge clk);
      end
      vectors++; if (ready !== 1'b1 || done_count != 1) begin miscompares++; $display("[TB] FAIL b2b_%0d_period got ready=%b pulses=%0d want 1 1", v, ready, done_count); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_multiply("basic", 8'h0D, 8'h0B, 16'h008F, 1'b0);
    test_multiply("carry", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    test_multiply("zero", 8'h5A, 8'h00, 16'h0000, 1'b1);
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
